// File: rtl/riscv_pipe_slice.sv
// Elastic pipeline segment: DEPTH register stages with per-stage valid and
// valid/ready handshakes on both sides. It closes up bubbles, stalls under
// downstream back-pressure, can flush the whole segment and reports how many
// stages are occupied.
module riscv_pipe_slice #(
    parameter  int unsigned DATA_W = 64,
    parameter  int unsigned DEPTH  = 2,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  occupancy,
    output logic              empty
);

    // Stage 0 is on the input side; stage DEPTH-1 drives out_data.
    logic [DEPTH-1:0]  r_vld;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_d;

    logic [DEPTH-1:0]  w_adv;      // stage contents may move on this cycle
    logic [DEPTH-1:0]  w_en;       // stage loads from its source this cycle
    logic [DEPTH-1:0]  w_vld_src;  // valid bit presented to each stage
    logic [DEPTH-1:0]  w_ld;       // data enable: only live payloads are copied
    logic [DEPTH-1:0]  w_vld_d;
    logic [DATA_W-1:0] w_dat [DEPTH];
    logic              w_adv_top;
    logic              w_in_fire;
    logic              w_out_fire;

    assign w_adv_top  = out_ready & ~flush_i;
    assign in_ready   = w_en[0] & ~flush_i & ~rst;
    assign out_valid  = r_vld[DEPTH-1] & ~flush_i;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign out_data   = w_dat[DEPTH-1];
    assign occupancy  = r_cnt;
    assign empty      = (r_cnt == '0);

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [DATA_W-1:0] r_dat;
        logic [DATA_W-1:0] w_src;

        if (g == 0) begin : g_head
            assign w_src        = in_data;
            assign w_vld_src[g] = w_in_fire;
        end else begin : g_body
            assign w_src        = w_dat[g-1];
            assign w_vld_src[g] = r_vld[g-1];
        end

        // The ripple "successor empty or moving" chain unrolls to: the output
        // stage is draining, or some later stage is a bubble.
        if (g == DEPTH - 1) begin : g_last
            assign w_adv[g] = w_adv_top;
        end else begin : g_mid
            assign w_adv[g] = w_adv_top | ~(&r_vld[DEPTH-1:g+1]);
        end

        // An empty stage always takes whatever its predecessor offers, which
        // is what packs entries toward the output while it is stalled.
        assign w_en[g] = ~r_vld[g] | w_adv[g];
        assign w_ld[g] = w_en[g] & w_vld_src[g] & ~flush_i;

        // Payload register: no reset, loads only when a live entry arrives.
        always_ff @(posedge clk) begin
            if (w_ld[g]) begin
                r_dat <= w_src;
            end
        end

        assign w_dat[g] = r_dat;
    end

    // Next valid vector: loading stages take their source's valid, others hold.
    always_comb begin
        w_vld_d = (w_en & w_vld_src) | (~w_en & r_vld);
        if (flush_i) begin
            w_vld_d = '0;
        end
    end

    // Next occupancy: +1 on accept, -1 on retire, cleared by flush.
    always_comb begin
        w_cnt_d = r_cnt;
        if (flush_i) begin
            w_cnt_d = '0;
        end else if (w_in_fire && !w_out_fire) begin
            w_cnt_d = r_cnt + CNT_W'(1);
        end else if (!w_in_fire && w_out_fire) begin
            w_cnt_d = r_cnt - CNT_W'(1);
        end
    end

    // Control state: valid bits and occupancy counter, async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_cnt <= '0;
        end else begin
            r_vld <= w_vld_d;
            r_cnt <= w_cnt_d;
        end
    end

`ifndef SYNTHESIS
    a_hold_stalled : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush_i) |=> $stable(out_data));
    a_cnt_range    : assert property (@(posedge clk) disable iff (rst)
        r_cnt <= CNT_W'(DEPTH));
    a_cnt_popcount : assert property (@(posedge clk) disable iff (rst)
        r_cnt == CNT_W'($countones(r_vld)));
`endif

endmodule
